// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler accumulator: op encodings and the
// width of one shadow-stack entry ({carry, acc}).
package nibbler_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  function automatic int entry_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/acc_shadow_lifo.sv
// Small LIFO holding saved {carry, acc} entries. Supports push, pop and an
// in-place swap of the top entry when push and pop coincide on a non-empty stack.
module acc_shadow_lifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [EW-1:0]              din,
  output logic [EW-1:0]              top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0] mem [DEPTH];
  logic [DW-1:0] cnt;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          swap;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == DW'(DEPTH));
  assign empty   = (cnt == '0);
  assign depth   = cnt;
  assign top_idx = AW'(cnt - DW'(1));
  assign wr_idx  = AW'(cnt);
  assign top     = empty ? '0 : mem[top_idx];

  // A coincident pop on an empty stack degrades to a plain push.
  assign swap    = push && pop && !empty;
  assign do_push = push && !full && !(pop && !empty);
  assign do_pop  = pop && !push && !empty;
  assign ovf     = push && !pop && full;
  assign udf     = pop && !push && empty;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + DW'(1);
    end else if (do_pop) begin
      cnt <= cnt - DW'(1);
    end
  end

  // NOTE: the storage array has no reset; its contents are only ever read
  // below the occupancy count, which is reset, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (swap) begin
      mem[top_idx] <= din;
    end else if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/accumulator_stack.sv
// Nibbler accumulator: op-selected update of {carry, acc}, derived zero flag,
// and a shadow LIFO for saving/restoring the pair with sticky error flags.
module accumulator_stack
  import nibbler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enable,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           Data,
  input  logic                       save,
  input  logic                       restore,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           Q,
  output logic                       carry,
  output logic                       zero,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err_ovf,
  output logic                       err_udf
);

  localparam int EW = entry_width(WIDTH);

  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic [EW-1:0]    nxt;
  logic [EW-1:0]    top;
  logic             ovf;
  logic             udf;
  logic             take_top;

  assign Q     = acc;
  assign carry = carry_q;
  assign zero  = (acc == '0);

  // Result of the selected op, packed as {carry, acc}.
  always_comb begin
    nxt = {carry_q, acc};
    case (op)
      OP_LOAD: nxt = {carry_q, Data};
      OP_INC:  nxt = {1'b0, acc} + EW'(1);
      OP_DEC:  nxt = {(acc == '0), acc - WIDTH'(1)};
      OP_SHL:  nxt = {acc[WIDTH-1], acc[WIDTH-2:0], 1'b0};
      OP_SHR:  nxt = {acc[0], 1'b0, acc[WIDTH-1:1]};
      OP_ROL:  nxt = {acc[WIDTH-1], acc[WIDTH-2:0], carry_q};
      OP_ROR:  nxt = {acc[0], carry_q, acc[WIDTH-1:1]};
      default: nxt = {carry_q, acc};
    endcase
  end

  acc_shadow_lifo #(
    .DEPTH(DEPTH),
    .EW   (EW)
  ) u_lifo (
    .clk  (CLK),
    .reset(RESET),
    .push (save),
    .pop  (restore),
    .din  ({carry_q, acc}),
    .top  (top),
    .depth(depth),
    .full (full),
    .empty(empty),
    .ovf  (ovf),
    .udf  (udf)
  );

  // A restore that actually pops (alone or as a swap) overrides the op.
  assign take_top = restore && !empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc     <= '0;
      carry_q <= 1'b0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (take_top) begin
        {carry_q, acc} <= top;
      end else if (enable) begin
        {carry_q, acc} <= nxt;
      end
      err_ovf <= (err_ovf && !clr_err) || ovf;
      err_udf <= (err_udf && !clr_err) || udf;
    end
  end

endmodule

// File: tb/tb_accumulator_stack.sv
// Directed bench for accumulator_stack (WIDTH=4, DEPTH=4): a table of
// per-cycle vectors with hand-computed results, then multi-cycle sequences.
module tb_accumulator_stack;
  import nibbler_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [3:0] data;
    logic       sv;
    logic       rs;
    logic       clr;
    logic [3:0] eq;
    logic       ec;
    logic [2:0] ed;
    logic       eo;
    logic       eu;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET, enable, save, restore, clr_err;
  logic [2:0] op;
  logic [3:0] Data;
  logic [3:0] Q;
  logic       carry, zero, full, empty, err_ovf, err_udf;
  logic [2:0] depth;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  accumulator_stack #(.WIDTH(4), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .op(op), .Data(Data),
    .save(save), .restore(restore), .clr_err(clr_err),
    .Q(Q), .carry(carry), .zero(zero), .depth(depth), .full(full),
    .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, en, input logic [2:0] o, input logic [3:0] d,
                              input logic sv, rs, clr, input logic [3:0] eq, input logic ec,
                              input logic [2:0] ed, input logic eo, eu);
    vec_t v;
    v.rst = rst; v.en = en; v.op = o; v.data = d; v.sv = sv; v.rs = rs; v.clr = clr;
    v.eq = eq; v.ec = ec; v.ed = ed; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  // Drive one cycle, then compare every output 1 time unit after the edge.
  task automatic apply(input vec_t v, input string tag);
    RESET = v.rst; enable = v.en; op = v.op; Data = v.data;
    save = v.sv; restore = v.rs; clr_err = v.clr;
    @(posedge CLK);
    #1;
    check({tag, ".Q"}, 32'(Q), 32'(v.eq));
    check({tag, ".carry"}, 32'(carry), 32'(v.ec));
    check({tag, ".zero"}, 32'(zero), 32'(v.eq == 4'h0));
    check({tag, ".depth"}, 32'(depth), 32'(v.ed));
    check({tag, ".full"}, 32'(full), 32'(v.ed == 3'd4));
    check({tag, ".empty"}, 32'(empty), 32'(v.ed == 3'd0));
    check({tag, ".err_ovf"}, 32'(err_ovf), 32'(v.eo));
    check({tag, ".err_udf"}, 32'(err_udf), 32'(v.eu));
  endtask

  initial begin
    //              rst en op       data sv rs clr  Q    c  dep ovf udf
    vecs.push_back(mk(1, 1, OP_LOAD, 4'hA, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'hA, 0, 0, 0, 4'hA, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_INC,  4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_DEC,  4'h0, 0, 0, 0, 4'hF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_DEC,  4'h0, 0, 0, 0, 4'hE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h9, 0, 0, 0, 4'h9, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ROL,  4'h0, 0, 0, 0, 4'h2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_ROR,  4'h0, 0, 0, 0, 4'h9, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h1, 0, 0, 0, 4'h1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_SHR,  4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h4, 0, 0, 0, 4'h4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_SHL,  4'h0, 0, 0, 0, 4'h8, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_SHL,  4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, OP_LOAD, 4'h7, 0, 0, 0, 4'h0, 1, 0, 0, 0));
    // Fill the stack with {1,1},{1,2},{1,3},{1,4}; op runs alongside each save.
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h1, 0, 0, 0, 4'h1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h2, 1, 0, 0, 4'h2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h3, 1, 0, 0, 4'h3, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, OP_LOAD, 4'h4, 1, 0, 0, 4'h4, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 1, 0, 0, 4'h4, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, OP_INC,  4'h0, 1, 0, 0, 4'h5, 0, 4, 1, 0));
    vecs.push_back(mk(0, 1, OP_INC,  4'h0, 0, 1, 0, 4'h4, 1, 3, 1, 0));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 0, 1, 0, 4'h3, 1, 2, 1, 0));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 0, 1, 0, 4'h2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 0, 1, 0, 4'h1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 0, 1, 0, 4'h1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 0, 0, 1, 4'h1, 1, 0, 0, 0));
    // Set beats clear: empty restore with clr_err; the op still executes.
    vecs.push_back(mk(0, 1, OP_INC,  4'h0, 0, 1, 1, 4'h2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, OP_HOLD, 4'h0, 0, 0, 1, 4'h2, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Swap: Q=5 with top {0,9}; save+restore+INC gives Q=9, top becomes {0,5}.
    apply(mk(0, 1, OP_LOAD, 4'h9, 0, 0, 0, 4'h9, 0, 0, 0, 0), "sw_ld9");
    apply(mk(0, 1, OP_LOAD, 4'h5, 1, 0, 0, 4'h5, 0, 1, 0, 0), "sw_push");
    apply(mk(0, 1, OP_INC,  4'h0, 1, 1, 0, 4'h9, 0, 1, 0, 0), "sw_swap");
    apply(mk(0, 1, OP_HOLD, 4'h0, 0, 1, 0, 4'h5, 0, 0, 0, 0), "sw_pop5");

    // Restore alone discards the op: top {0,5}, Q=7, INC would give 8.
    apply(mk(0, 1, OP_LOAD, 4'h7, 1, 0, 0, 4'h7, 0, 1, 0, 0), "rs_push");
    apply(mk(0, 1, OP_INC,  4'h0, 0, 1, 0, 4'h5, 0, 0, 0, 0), "rs_inc");

    // Swap on empty stack is a plain push; op executes, no error.
    apply(mk(0, 1, OP_INC,  4'h0, 1, 1, 0, 4'h6, 0, 1, 0, 0), "se_push");
    // enable=0 still lets save through and holds acc.
    apply(mk(0, 0, OP_LOAD, 4'hF, 1, 0, 0, 4'h6, 0, 2, 0, 0), "en0_save");
    apply(mk(0, 0, OP_LOAD, 4'hF, 1, 0, 0, 4'h6, 0, 3, 0, 0), "en0_save2");

    // Reset mid-operation wins over save, then restore underflows.
    apply(mk(1, 1, OP_INC,  4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 0), "rst_mid");
    apply(mk(0, 1, OP_HOLD, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0, 1), "rst_udf");
    apply(mk(1, 1, OP_HOLD, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0), "rst_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_stack.md
Name: accumulator_stack

Overview:
- Parametrised accumulator register for the Nibbler datapath, replacing the fixed 4-bit load/hold accumulator.
- Adds an op-selected update path (load, increment, decrement, shift, rotate through carry), registered carry, and a derived zero flag.
- Adds a small LIFO shadow stack for saving and restoring accumulator plus carry around subroutine or interrupt entry.
- Sits between the ALU result bus and the ALU A-operand / flag-test logic.

Parameters:
WIDTH, 4, accumulator and data width in bits (>=2)
DEPTH, 4, shadow stack entries (>=1)

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  synchronous active-high reset
enable  in  1  qualifies op; 0 = hold acc and carry
op  in  3  operation select, see Behaviour
Data  in  WIDTH  load value (ALU result / bus)
save  in  1  push {carry, acc} onto shadow stack
restore  in  1  pop shadow stack into {carry, acc}
clr_err  in  1  clear sticky error flags
Q  out  WIDTH  accumulator value
carry  out  1  registered carry flag
zero  out  1  combinational, 1 when Q == 0
depth  out  clog2(DEPTH+1)  occupied stack entries
full  out  1  depth == DEPTH
empty  out  1  depth == 0
err_ovf  out  1  sticky: save attempted while full
err_udf  out  1  sticky: restore attempted while empty

Behaviour:
- Reset: RESET sampled at the clock edge, highest priority over every other input.
  - Q=0, carry=0 (so zero=1), depth=0 (empty=1, full=0), err_ovf=0, err_udf=0.
  - Stack contents are don't-care after reset.
- Op encoding, applied only when enable=1 and no restore is taking effect:
  - 000 HOLD: no change.
  - 001 LOAD: acc<=Data; carry unchanged.
  - 010 INC: {carry,acc}<=acc+1, i.e. carry=1 only on wrap from all-ones to 0.
  - 011 DEC: acc<=acc-1 mod 2^WIDTH; carry=1 (borrow) only when acc was 0.
  - 100 SHL: carry<=acc[MSB]; acc<={acc[WIDTH-2:0],0}.
  - 101 SHR: carry<=acc[0]; acc<={0,acc[WIDTH-1:1]}.
  - 110 ROL, through carry: acc<={acc[WIDTH-2:0],carry}; carry<=acc[MSB].
  - 111 ROR, through carry: acc<={carry,acc[WIDTH-1:1]}; carry<=acc[0].
- Latency: one cycle. The result is visible on Q/carry/zero after the edge that samples the op.
- Save alone:
  - Not full: push the pre-edge {carry,acc}; depth+1.
  - Full: stack and depth unchanged; err_ovf<=1.
  - Any op with enable=1 executes in the same cycle on the pre-edge value.
- Restore alone:
  - Not empty: {carry,acc}<=top; depth-1. Any op in the same cycle is discarded.
  - Empty: acc/carry unchanged; err_udf<=1. The op still executes normally.
- Save and restore in the same cycle (swap):
  - Not empty: {carry,acc}<=top, top<=pre-edge {carry,acc}, depth unchanged, op discarded.
  - Empty: push only (as save alone), no error, op executes.
- clr_err=1 clears both sticky errors. If a new error condition occurs in the same cycle, the set wins.
- Stack pointer never wraps: depth stays within 0..DEPTH under all input sequences.
- enable=0 does not block save/restore.

Decomposition:
- Shared package (nibbler_pkg): op encodings as named localparams (OP_HOLD..OP_ROR) and the stack entry width expression WIDTH+1.
- One sub-module: acc_shadow_lifo.
  - Parametrised DEPTH x (WIDTH+1) LIFO with push, pop, swap, depth, full, empty, ovf, udf.
  - The top level holds the acc/carry update mux, the priority logic and the sticky flags.

Test Plan:
- Reset then idle: assert RESET one cycle with enable=1, op=LOAD, Data=4'hA -> Q=0, carry=0, zero=1, empty=1, depth=0. Next cycle with RESET low -> Q=4'hA.
- Arithmetic wrap: LOAD 4'hF, INC -> Q=0, carry=1, zero=1. Then DEC -> Q=4'hF, carry=1 (borrow). Then DEC -> Q=4'hE, carry=0.
- Rotate through carry: LOAD 4'b1001 with carry=0, ROL -> Q=4'b0010, carry=1. Then ROR -> Q=4'b1001, carry=0. SHR on 4'b0001 -> Q=0, carry=1.
- Stack fill and overflow (DEPTH=4): save with Q=1,2,3,4 -> full=1, depth=4. A fifth save -> depth=4, err_ovf=1. Then four restores -> Q=4,3,2,1. A fifth restore -> Q=1 unchanged, err_udf=1. Then clr_err -> both errors 0.
- Simultaneous events: Q=5, stack top=9, save+restore+op=INC -> Q=9, top=5, depth unchanged. Q=5, restore alone with op=INC -> Q=top and INC ignored.
- Reset mid-operation: stack depth=3 and RESET asserted with save=1 -> depth=0, Q=0, errors 0. The following restore -> err_udf=1.
